tape_transport_ctrl: RTL and testbench
======================================

TAPE_TRANSPORT_CTRL -- requirements
Module: tape_transport_ctrl

Interface
REQ-001 Parameter POS_W, default 8: width of the tape position counter.
REQ-002 Parameter TAPE_LEN, default 64: number of tape positions; the legal range is 0..TAPE_LEN-1, with 2 <= TAPE_LEN <= 2**POS_W.
REQ-003 Parameter FAST_STEP, default 4: position change per cycle in REWIND and FFWD; 1 <= FAST_STEP < TAPE_LEN.
REQ-004 Parameter SLOW_DIV, default 4: number of cycles per single-position step in SLOWB and SLOWF; SLOW_DIV >= 2.
REQ-005 Port Clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-006 Port Rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 Port PL, input, 1 bit: play key, level-sensitive.
REQ-008 Port RE, input, 1 bit: rewind key.
REQ-009 Port FF, input, 1 bit: fast-forward key.
REQ-010 Port ST, input, 1 bit: stop key.
REQ-011 Port M, input, 1 bit: hold for slow mode; 0 releases slow mode back to PLAY.
REQ-012 Port P, output, 1 bit: play motor.
REQ-013 Port R, output, 1 bit: reverse motor.
REQ-014 Port F, output, 1 bit: forward motor.
REQ-015 Port pos, output, POS_W bits: current tape position, registered.
REQ-016 Port bot, output, 1 bit: beginning of tape, asserted when pos == 0.
REQ-017 Port eot, output, 1 bit: end of tape, asserted when pos == TAPE_LEN-1.

Function
REQ-018 The block SHALL be a Moore machine with six states: IDLE, REWIND, PLAY, FFWD, SLOWB, SLOWF.
REQ-019 Outputs SHALL decode from the state only:
- IDLE: P/R/F = 000
- REWIND: 010
- PLAY: 100
- FFWD: 001
- SLOWB: 010
- SLOWF: 001
REQ-020 IDLE transitions, in priority order:
- RE & !bot -> REWIND
- PL & !eot -> PLAY
- FF & !eot -> FFWD
- otherwise stay in IDLE
REQ-021 REWIND transitions:
- ST | FF -> IDLE
- PL -> PLAY
- otherwise stay in REWIND
REQ-022 PLAY transitions:
- ST | !PL -> IDLE
- RE -> SLOWB
- FF -> SLOWF
- otherwise stay in PLAY
REQ-023 FFWD transitions:
- ST | RE -> IDLE
- PL -> PLAY
- otherwise stay in FFWD
REQ-024 SLOWB and SLOWF transitions:
- ST -> IDLE
- !M -> PLAY
- otherwise stay
REQ-025 Position update per cycle, applied based on the current state:
- PLAY: +1
- FFWD: +FAST_STEP
- REWIND: -FAST_STEP
- SLOWF: +1 when the divider reaches SLOW_DIV-1
- SLOWB: -1 when the divider reaches SLOW_DIV-1
- IDLE: hold
REQ-026 Position arithmetic SHALL use POS_W+1 bits and saturate to the range 0..TAPE_LEN-1; pos SHALL never wrap.
REQ-027 If the updated position equals the end limit for the direction of travel (0 for R states, TAPE_LEN-1 for P and F states), the next state SHALL be IDLE. This auto-stop overrides every key-driven transition in the same cycle.
REQ-028 The slow divider SHALL be a counter that wraps at SLOW_DIV-1. It is cleared on every entry into SLOWB or SLOWF and held at 0 in all other states.
REQ-029 Simultaneous keys SHALL resolve strictly by the priority orders in REQ-020 to REQ-024; ST wins in every non-IDLE state.
REQ-030 bot and eot SHALL be combinational compares of the registered pos and therefore valid in the same cycle as pos.

Reset
REQ-031 While Rst=1 at a rising edge, the block SHALL set state=IDLE, pos=0 and divider=0, giving P=R=F=0, bot=1, eot=0 on the next cycle.
REQ-032 Rst asserted mid-operation (any state, any pos) SHALL discard that cycle's transition and position update.

Structure
REQ-033 The state encoding (3-bit) and the P/R/F output encoding constants SHALL live in shared package tape_pkg.
REQ-034 Position and divider arithmetic SHALL be in sub-module tape_pos_counter, which takes dir, step and enable and produces pos, bot and eot. The FSM stays in the top level.

Verification (defaults: POS_W=8, TAPE_LEN=64, FAST_STEP=4, SLOW_DIV=4)
REQ-035 Reset, then PL=1 held for 10 cycles -> P=1 from cycle 1 and pos=10 after the 10th PLAY cycle; drop PL -> IDLE with pos held at 10.
REQ-036 From pos=60, FF pulse -> FFWD; the next update saturates pos at 63 -> IDLE, eot=1, and a subsequent FF pulse is ignored.
REQ-037 From pos=10, RE pulse -> REWIND: pos steps 6, 2, 0 -> IDLE with bot=1, and a following RE is ignored.
REQ-038 In PLAY at pos=20, raise RE with M=1 -> SLOWB: pos decrements once per 4 cycles; drop M -> PLAY, R=0, P=1.
REQ-039 In FFWD, raise ST, RE and PL in the same cycle -> IDLE (ST has priority); assert Rst during SLOWF at pos=30 -> pos=0 and IDLE on the next edge.

Source files
------------

// File: rtl/tape_pkg.sv
// Shared encodings for the tape transport controller: FSM state codes
// and the P/R/F motor patterns each state drives.
package tape_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REWIND = 3'd1,
        S_PLAY   = 3'd2,
        S_FFWD   = 3'd3,
        S_SLOWB  = 3'd4,
        S_SLOWF  = 3'd5
    } state_t;

    // Motor patterns, ordered {P, R, F}
    localparam logic [2:0] PRF_IDLE   = 3'b000;
    localparam logic [2:0] PRF_REWIND = 3'b010;
    localparam logic [2:0] PRF_PLAY   = 3'b100;
    localparam logic [2:0] PRF_FFWD   = 3'b001;
    localparam logic [2:0] PRF_SLOWB  = 3'b010;
    localparam logic [2:0] PRF_SLOWF  = 3'b001;

    function automatic logic [2:0] prf_of(input state_t s);
        logic [2:0] prf;
        case (s)
            S_REWIND: prf = PRF_REWIND;
            S_PLAY:   prf = PRF_PLAY;
            S_FFWD:   prf = PRF_FFWD;
            S_SLOWB:  prf = PRF_SLOWB;
            S_SLOWF:  prf = PRF_SLOWF;
            default:  prf = PRF_IDLE;
        endcase
        return prf;
    endfunction

endpackage

// File: rtl/tape_pos_counter.sv
// Tape position register with saturating step arithmetic and the slow-mode
// divider. Exposes the position it will load next so the FSM can detect
// reaching the end of travel in the same cycle.
module tape_pos_counter #(
    parameter int POS_W    = 8,
    parameter int TAPE_LEN = 64,
    parameter int SLOW_DIV = 4
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             i_en,
    input  logic             i_dir,
    input  logic             i_slow,
    input  logic [POS_W-1:0] i_step,
    output logic [POS_W-1:0] o_pos,
    output logic [POS_W-1:0] o_next_pos,
    output logic             o_bot,
    output logic             o_eot
);

    localparam int               DIV_W    = $clog2(SLOW_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SLOW_DIV - 1);
    localparam logic [POS_W-1:0] MAX_POS  = POS_W'(TAPE_LEN - 1);
    localparam logic [POS_W:0]   MAX_EXT  = (POS_W + 1)'(TAPE_LEN - 1);

    logic [POS_W-1:0] r_pos;
    logic [DIV_W-1:0] r_div;
    logic [POS_W:0]   w_sum;
    logic [POS_W-1:0] w_diff;
    logic             w_move;

    // One extra bit on the forward sum so an overshoot past the end is
    // visible before it is clamped.
    assign w_sum  = {1'b0, r_pos} + {1'b0, i_step};
    assign w_diff = r_pos - i_step;

    // Next position: hold, or step in the requested direction and clamp
    always_comb begin
        w_move     = i_en && (!i_slow || (r_div == DIV_LAST));
        o_next_pos = r_pos;
        if (w_move) begin
            if (i_dir) begin
                o_next_pos = (w_sum > MAX_EXT) ? MAX_POS : w_sum[POS_W-1:0];
            end else begin
                o_next_pos = (i_step > r_pos) ? '0 : w_diff;
            end
        end
    end

    // Position and divider registers; divider idles at 0 outside slow modes
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_pos <= '0;
            r_div <= '0;
        end else begin
            r_pos <= o_next_pos;
            if (!i_slow || (r_div == DIV_LAST)) begin
                r_div <= '0;
            end else begin
                r_div <= r_div + DIV_W'(1);
            end
        end
    end

    assign o_pos = r_pos;
    assign o_bot = (r_pos == '0);
    assign o_eot = (r_pos == MAX_POS);

endmodule

// File: rtl/tape_transport_ctrl.sv
// Tape transport controller: six-state Moore FSM driving the play,
// reverse and forward motors from the front-panel keys, with automatic
// stop at either end of the tape.
module tape_transport_ctrl
    import tape_pkg::*;
#(
    parameter int POS_W     = 8,
    parameter int TAPE_LEN  = 64,
    parameter int FAST_STEP = 4,
    parameter int SLOW_DIV  = 4
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             PL,
    input  logic             RE,
    input  logic             FF,
    input  logic             ST,
    input  logic             M,
    output logic             P,
    output logic             R,
    output logic             F,
    output logic [POS_W-1:0] pos,
    output logic             bot,
    output logic             eot,
    output logic [2:0]       o_state
);

    localparam logic [POS_W-1:0] MAX_POS   = POS_W'(TAPE_LEN - 1);
    localparam logic [POS_W-1:0] STEP_FAST = POS_W'(FAST_STEP);
    localparam logic [POS_W-1:0] STEP_ONE  = POS_W'(1);

    state_t           r_state;
    state_t           w_key_next;
    state_t           w_state_next;
    logic             w_en;
    logic             w_dir;
    logic             w_slow;
    logic [POS_W-1:0] w_step;
    logic [POS_W-1:0] w_next_pos;
    logic             w_at_limit;

    tape_pos_counter #(
        .POS_W    (POS_W),
        .TAPE_LEN (TAPE_LEN),
        .SLOW_DIV (SLOW_DIV)
    ) u_pos (
        .Clk        (Clk),
        .Rst        (Rst),
        .i_en       (w_en),
        .i_dir      (w_dir),
        .i_slow     (w_slow),
        .i_step     (w_step),
        .o_pos      (pos),
        .o_next_pos (w_next_pos),
        .o_bot      (bot),
        .o_eot      (eot)
    );

    // Movement request for the counter, decoded from the current state
    always_comb begin
        w_en   = 1'b0;
        w_dir  = 1'b1;
        w_slow = 1'b0;
        w_step = STEP_ONE;
        case (r_state)
            S_PLAY: begin
                w_en = 1'b1;
            end
            S_FFWD: begin
                w_en   = 1'b1;
                w_step = STEP_FAST;
            end
            S_REWIND: begin
                w_en   = 1'b1;
                w_dir  = 1'b0;
                w_step = STEP_FAST;
            end
            S_SLOWF: begin
                w_en   = 1'b1;
                w_slow = 1'b1;
            end
            S_SLOWB: begin
                w_en   = 1'b1;
                w_dir  = 1'b0;
                w_slow = 1'b1;
            end
            default: begin
                w_en = 1'b0;
            end
        endcase
        // Reaching the end we are travelling towards forces a stop
        w_at_limit = w_en && (w_dir ? (w_next_pos == MAX_POS) : (w_next_pos == '0));
    end

    // Key-driven next state in priority order, then end-of-travel override
    always_comb begin
        w_key_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (RE && !bot)      w_key_next = S_REWIND;
                else if (PL && !eot) w_key_next = S_PLAY;
                else if (FF && !eot) w_key_next = S_FFWD;
            end
            S_REWIND: begin
                if (ST || FF) w_key_next = S_IDLE;
                else if (PL)  w_key_next = S_PLAY;
            end
            S_PLAY: begin
                if (ST || !PL) w_key_next = S_IDLE;
                else if (RE)   w_key_next = S_SLOWB;
                else if (FF)   w_key_next = S_SLOWF;
            end
            S_FFWD: begin
                if (ST || RE) w_key_next = S_IDLE;
                else if (PL)  w_key_next = S_PLAY;
            end
            S_SLOWB, S_SLOWF: begin
                if (ST)      w_key_next = S_IDLE;
                else if (!M) w_key_next = S_PLAY;
            end
            default: begin
                w_key_next = S_IDLE;
            end
        endcase
        w_state_next = w_at_limit ? S_IDLE : w_key_next;
    end

    // State register
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    assign {P, R, F} = prf_of(r_state);
    assign o_state   = r_state;

endmodule

// File: tb/tb_tape_transport_ctrl.sv
// Bench for tape_transport_ctrl: directed scenarios plus a random run,
// each cycle checked against a cycle-level reference model.
module tb_tape_transport_ctrl;
    import tape_pkg::*;

    localparam int POS_W     = 8;
    localparam int TAPE_LEN  = 64;
    localparam int FAST_STEP = 4;
    localparam int SLOW_DIV  = 4;
    localparam int W         = 16;

    logic             Clk = 1'b0;
    logic             Rst = 1'b0;
    logic             PL = 1'b0, RE = 1'b0, FF = 1'b0, ST = 1'b0, M = 1'b0;
    logic             P, R, F, bot, eot;
    logic [POS_W-1:0] pos;
    logic [2:0]       o_state;

    int             errors = 0;
    int             checks = 0;
    logic [W-1:0]   exp_q[$];
    logic [W-1:0]   obs;
    logic [W-1:0]   exp_v;

    state_t m_state = S_IDLE;
    int     m_pos   = 0;
    int     m_div   = 0;

    tape_transport_ctrl #(
        .POS_W     (POS_W),
        .TAPE_LEN  (TAPE_LEN),
        .FAST_STEP (FAST_STEP),
        .SLOW_DIV  (SLOW_DIV)
    ) dut (
        .Clk     (Clk),
        .Rst     (Rst),
        .PL      (PL),
        .RE      (RE),
        .FF      (FF),
        .ST      (ST),
        .M       (M),
        .P       (P),
        .R       (R),
        .F       (F),
        .pos     (pos),
        .bot     (bot),
        .eot     (eot),
        .o_state (o_state)
    );

    // Clock
    always #5 Clk = ~Clk;

    function automatic logic [W-1:0] model_vec();
        logic [2:0] prf;
        case (m_state)
            S_REWIND: prf = 3'b010;
            S_PLAY:   prf = 3'b100;
            S_FFWD:   prf = 3'b001;
            S_SLOWB:  prf = 3'b010;
            S_SLOWF:  prf = 3'b001;
            default:  prf = 3'b000;
        endcase
        return {m_state, prf, POS_W'(m_pos), (m_pos == 0), (m_pos == TAPE_LEN - 1)};
    endfunction

    // Drive one cycle of keys, advance the model, queue the expected outputs
    task automatic drive_cycle(input logic rst, pl, re, ff, st, m);
        int     delta;
        int     np;
        state_t nx;
        Rst = rst; PL = pl; RE = re; FF = ff; ST = st; M = m;
        if (rst) begin
            m_state = S_IDLE;
            m_pos   = 0;
            m_div   = 0;
        end else begin
            delta = 0;
            case (m_state)
                S_PLAY:   delta = 1;
                S_FFWD:   delta = FAST_STEP;
                S_REWIND: delta = -FAST_STEP;
                S_SLOWF:  delta = (m_div == SLOW_DIV - 1) ? 1 : 0;
                S_SLOWB:  delta = (m_div == SLOW_DIV - 1) ? -1 : 0;
                default:  delta = 0;
            endcase
            np = m_pos + delta;
            if (np < 0) np = 0;
            if (np > TAPE_LEN - 1) np = TAPE_LEN - 1;
            nx = m_state;
            case (m_state)
                S_IDLE: begin
                    if (re && m_pos != 0)                  nx = S_REWIND;
                    else if (pl && m_pos != TAPE_LEN - 1)  nx = S_PLAY;
                    else if (ff && m_pos != TAPE_LEN - 1)  nx = S_FFWD;
                end
                S_REWIND: nx = (st || ff) ? S_IDLE : (pl ? S_PLAY : S_REWIND);
                S_FFWD:   nx = (st || re) ? S_IDLE : (pl ? S_PLAY : S_FFWD);
                S_PLAY:   nx = (st || !pl) ? S_IDLE : (re ? S_SLOWB : (ff ? S_SLOWF : S_PLAY));
                default:  nx = st ? S_IDLE : (!m ? S_PLAY : m_state);
            endcase
            if ((m_state == S_REWIND || m_state == S_SLOWB) && np == 0) nx = S_IDLE;
            if ((m_state == S_PLAY || m_state == S_FFWD || m_state == S_SLOWF) &&
                np == TAPE_LEN - 1) nx = S_IDLE;
            m_div   = (m_state == S_SLOWB || m_state == S_SLOWF) ? (m_div + 1) % SLOW_DIV : 0;
            m_pos   = np;
            m_state = nx;
        end
        exp_q.push_back(model_vec());
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive_cycle(1, 1, 1, 1, 0, 1);
            obs = {o_state, P, R, F, pos, bot, eot}; exp_v = exp_q.pop_front(); checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL reset[%0d]: got %h, expected %h", i, obs, exp_v); end
        end
        checks++;
        if ({P, R, F, bot, eot} !== 5'b00010) begin
            errors++; $display("FAIL reset_outputs: got PRF/bot/eot %b, expected 00010", {P, R, F, bot, eot});
        end
    endtask

    // Hold PL ten cycles, drop it on the eleventh
    task automatic play_to_10(input string tag);
        for (int i = 0; i < 11; i++) begin
            drive_cycle(0, i < 10, 0, 0, 0, 0);
            obs = {o_state, P, R, F, pos, bot, eot}; exp_v = exp_q.pop_front(); checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL %s[%0d]: got %h, expected %h", tag, i, obs, exp_v); end
        end
        checks++;
        if (pos !== 8'd10 || P !== 1'b0) begin
            errors++; $display("FAIL %s_end: got pos=%0d P=%b, expected pos=10 P=0", tag, pos, P);
        end
    endtask

    task automatic test_play();
        drive_cycle(0, 1, 0, 0, 0, 0);
        obs = {o_state, P, R, F, pos, bot, eot}; exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v || P !== 1'b1 || pos !== 8'd0) begin
            errors++; $display("FAIL play_entry: got %h, expected %h with P=1 pos=0", obs, exp_v);
        end
        for (int i = 0; i < 10; i++) begin
            drive_cycle(0, i < 9, 0, 0, 0, 0);
            obs = {o_state, P, R, F, pos, bot, eot}; exp_v = exp_q.pop_front(); checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL play[%0d]: got %h, expected %h", i, obs, exp_v); end
        end
        drive_cycle(0, 0, 0, 0, 0, 0);
        obs = {o_state, P, R, F, pos, bot, eot}; exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v || pos !== 8'd10 || o_state !== S_IDLE) begin
            errors++; $display("FAIL play_hold: got %h pos=%0d, expected %h pos=10", obs, pos, exp_v);
        end
    endtask

    task automatic test_ffwd_eot();
        for (int i = 0; i < 51; i++) begin
            drive_cycle(0, i < 50, 0, 0, 0, 0);
            obs = {o_state, P, R, F, pos, bot, eot}; exp_v = exp_q.pop_front(); checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL play_to_60[%0d]: got %h, expected %h", i, obs, exp_v); end
        end
        checks++;
        if (pos !== 8'd60) begin errors++; $display("FAIL pos60: got %0d, expected 60", pos); end
        for (int i = 0; i < 4; i++) begin
            drive_cycle(0, 0, 0, (i == 0 || i == 2), 0, 0);
            obs = {o_state, P, R, F, pos, bot, eot}; exp_v = exp_q.pop_front(); checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL ffwd_eot[%0d]: got %h, expected %h", i, obs, exp_v); end
        end
        checks++;
        if (pos !== 8'd63 || eot !== 1'b1 || F !== 1'b0 || o_state !== S_IDLE) begin
            errors++; $display("FAIL eot_stop: got pos=%0d eot=%b F=%b, expected pos=63 eot=1 F=0", pos, eot, F);
        end
    endtask

    task automatic test_rewind_bot();
        int exp_pos[3] = '{6, 2, 0};
        drive_cycle(1, 0, 0, 0, 0, 0);
        void'(exp_q.pop_front());
        play_to_10("play_to_10");
        drive_cycle(0, 0, 1, 0, 0, 0);
        obs = {o_state, P, R, F, pos, bot, eot}; exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v || R !== 1'b1) begin errors++; $display("FAIL rewind_entry: got %h, expected %h", obs, exp_v); end
        for (int i = 0; i < 3; i++) begin
            drive_cycle(0, 0, 0, 0, 0, 0);
            obs = {o_state, P, R, F, pos, bot, eot}; exp_v = exp_q.pop_front(); checks++;
            if (obs !== exp_v || pos !== POS_W'(exp_pos[i])) begin
                errors++; $display("FAIL rewind[%0d]: got %h pos=%0d, expected %h pos=%0d", i, obs, pos, exp_v, exp_pos[i]);
            end
        end
        drive_cycle(0, 0, 1, 0, 0, 0);
        obs = {o_state, P, R, F, pos, bot, eot}; exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v || R !== 1'b0 || bot !== 1'b1) begin
            errors++; $display("FAIL rewind_at_bot: got %h, expected %h", obs, exp_v);
        end
    endtask

    task automatic test_slow();
        drive_cycle(1, 0, 0, 0, 0, 0);
        void'(exp_q.pop_front());
        for (int i = 0; i < 21; i++) begin
            drive_cycle(0, 1, 0, 0, 0, 0);
            obs = {o_state, P, R, F, pos, bot, eot}; exp_v = exp_q.pop_front(); checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL play_to_20[%0d]: got %h, expected %h", i, obs, exp_v); end
        end
        checks++;
        if (pos !== 8'd20 || P !== 1'b1) begin errors++; $display("FAIL pos20: got pos=%0d P=%b, expected 20 1", pos, P); end
        drive_cycle(0, 1, 1, 0, 0, 1);
        obs = {o_state, P, R, F, pos, bot, eot}; exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v || R !== 1'b1 || o_state !== S_SLOWB) begin
            errors++; $display("FAIL slowb_entry: got %h, expected %h", obs, exp_v);
        end
        for (int i = 0; i < 8; i++) begin
            drive_cycle(0, 1, 0, 0, 0, 1);
            obs = {o_state, P, R, F, pos, bot, eot}; exp_v = exp_q.pop_front(); checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL slowb[%0d]: got %h, expected %h", i, obs, exp_v); end
            if (i == 3 || i == 7) begin
                checks++;
                if (pos !== POS_W'(i == 3 ? 20 : 19)) begin
                    errors++; $display("FAIL slowb_div[%0d]: got pos=%0d, expected %0d", i, pos, (i == 3) ? 20 : 19);
                end
            end
        end
        drive_cycle(0, 1, 0, 0, 0, 0);
        obs = {o_state, P, R, F, pos, bot, eot}; exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v || R !== 1'b0 || P !== 1'b1 || pos !== 8'd19) begin
            errors++; $display("FAIL slow_release: got %h, expected %h", obs, exp_v);
        end
    endtask

    task automatic test_slowf_reset();
        for (int k = 0; k < 40 && m_pos < 29; k++) begin
            drive_cycle(0, 1, 0, 0, 0, 0);
            obs = {o_state, P, R, F, pos, bot, eot}; exp_v = exp_q.pop_front(); checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL play_to_29[%0d]: got %h, expected %h", k, obs, exp_v); end
        end
        drive_cycle(0, 1, 0, 1, 0, 1);
        obs = {o_state, P, R, F, pos, bot, eot}; exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v || F !== 1'b1 || pos !== 8'd30) begin
            errors++; $display("FAIL slowf_entry: got %h pos=%0d, expected %h pos=30", obs, pos, exp_v);
        end
        for (int i = 0; i < 2; i++) begin
            drive_cycle(0, 0, 0, 0, 0, 1);
            obs = {o_state, P, R, F, pos, bot, eot}; exp_v = exp_q.pop_front(); checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL slowf[%0d]: got %h, expected %h", i, obs, exp_v); end
        end
        drive_cycle(1, 1, 0, 1, 0, 1);
        obs = {o_state, P, R, F, pos, bot, eot}; exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v || pos !== 8'd0 || o_state !== S_IDLE || bot !== 1'b1) begin
            errors++; $display("FAIL slowf_reset: got %h, expected %h", obs, exp_v);
        end
    endtask

    task automatic test_priority();
        drive_cycle(0, 0, 0, 1, 0, 0);
        obs = {o_state, P, R, F, pos, bot, eot}; exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v || o_state !== S_FFWD) begin errors++; $display("FAIL prio_ffwd: got %h, expected %h", obs, exp_v); end
        drive_cycle(0, 1, 1, 0, 1, 0);
        obs = {o_state, P, R, F, pos, bot, eot}; exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v || o_state !== S_IDLE || pos !== 8'd4) begin
            errors++; $display("FAIL prio_stop: got %h, expected %h", obs, exp_v);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive_cycle($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0,
                        $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                        $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
            obs = {o_state, P, R, F, pos, bot, eot}; exp_v = exp_q.pop_front(); checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL random[%0d]: got %h, expected %h", i, obs, exp_v); end
        end
    endtask

    initial begin
        test_reset();
        test_play();
        test_ffwd_eot();
        test_rewind_bot();
        test_slow();
        test_slowf_reset();
        test_priority();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
